player_ctrl_multi: RTL and testbench

Parametrised successor to the two-player position logic in the VGA move-block game. It tracks the horizontal positions of NUM_PLAYERS paddles driven by debounced, active-low left/right key levels (board KEYs ANDed with Bluetooth keys). It adds auto-repeat on hold, saturating bounds, and inter-player collision blocking. It runs on CLOCK_50 and feeds packed positions to square_logic/render_logic.

---
 rtl/player_ctrl_multi.sv | 230 +++++++++++++++++++++++
 tb/tb_player_ctrl_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl_multi.sv
// Multi-player paddle position controller: key sampling, hold/auto-repeat FSMs,
// bounded moves and collision blocking. Define PLAYER_WRAP_EN for wrap-around at the edges.

module player_key_fsm #(
  parameter int HOLD_DLY      = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sample_ok,
  input  logic key_left_n,
  input  logic key_right_n,
  output logic req_left,
  output logic req_right
);
  // state     | meaning
  // IDLE      | waiting for a press edge on exactly one direction
  // WAIT_HOLD | press move issued, counting down HOLD_DLY before auto-repeat
  // REPEAT    | auto-repeat, one move every REPEAT_PERIOD cycles
  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;

  localparam int CNT_MAX = (HOLD_DLY > REPEAT_PERIOD) ? HOLD_DLY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       left_smp, right_smp;
  logic             left_cur, right_cur, left_edge, right_edge, held;
  logic             mv_left, mv_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_smp  <= 2'b11;
      right_smp <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      req_left  <= 1'b0;
      req_right <= 1'b0;
    end else begin
      left_smp  <= {left_smp[0], key_left_n};
      right_smp <= {right_smp[0], key_right_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      req_left  <= mv_left;
      req_right <= mv_right;
    end
  end

  // sample_ok masks the false edge seen when reset releases with a key already held
  assign left_cur   = ~left_smp[0];
  assign right_cur  = ~right_smp[0];
  assign left_edge  = sample_ok & left_smp[1] & ~left_smp[0];
  assign right_edge = sample_ok & right_smp[1] & ~right_smp[0];
  assign held       = dir_q ? (right_cur & ~left_cur) : (left_cur & ~right_cur);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mv_left  = 1'b0;
    mv_right = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && left_edge && !right_cur) begin
          mv_left = 1'b1;
          dir_d   = 1'b0;
          state_d = WAIT_HOLD;
          cnt_d   = CNT_W'(HOLD_DLY - 1);
        end else if (enable && right_edge && !left_cur) begin
          mv_right = 1'b1;
          dir_d    = 1'b1;
          state_d  = WAIT_HOLD;
          cnt_d    = CNT_W'(HOLD_DLY - 1);
        end
      end
      WAIT_HOLD, REPEAT: begin
        if (!enable || !held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          mv_left  = ~dir_q;
          mv_right = dir_q;
          state_d  = REPEAT;
          cnt_d    = CNT_W'(REPEAT_PERIOD - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module player_ctrl_multi #(
  parameter int NUM_PLAYERS   = 2,
  parameter int POS_W         = 10,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 620,
  parameter int X_INIT0       = 100,
  parameter int X_SPACING     = 300,
  parameter int STEP          = 20,
  parameter int MIN_GAP       = 40,
  parameter int HOLD_DLY      = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_PLAYERS-1:0]       key_left_n,
  input  logic [NUM_PLAYERS-1:0]       key_right_n,
  output logic [NUM_PLAYERS*POS_W-1:0] x,
  output logic [NUM_PLAYERS-1:0]       move_pulse,
  output logic [NUM_PLAYERS-1:0]       blocked,
  output logic [NUM_PLAYERS-1:0]       at_min,
  output logic [NUM_PLAYERS-1:0]       at_max
);
  typedef logic [POS_W:0] ext_t;

  logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
  logic [POS_W-1:0]       pos_d [NUM_PLAYERS];
  ext_t                   tgt   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] req_left, req_right, accept, refuse;
  logic [1:0]             warm_q;

  function automatic logic [POS_W-1:0] init_pos(input int i);
    return POS_W'(X_INIT0 + i * X_SPACING);
  endfunction

  function automatic ext_t step_left(input ext_t cur);
`ifdef PLAYER_WRAP_EN
    if (cur == ext_t'(X_MIN)) return ext_t'(X_MAX);
`endif
    if (cur >= ext_t'(X_MIN + STEP)) return cur - ext_t'(STEP);
    return ext_t'(X_MIN);
  endfunction

  function automatic ext_t step_right(input ext_t cur);
`ifdef PLAYER_WRAP_EN
    if (cur == ext_t'(X_MAX)) return ext_t'(X_MIN);
`endif
    if (cur + ext_t'(STEP) <= ext_t'(X_MAX)) return cur + ext_t'(STEP);
    return ext_t'(X_MAX);
  endfunction

  function automatic logic gap_lt(input ext_t a, input ext_t b);
    ext_t d;
    d = (a > b) ? (a - b) : (b - a);
    return int'(d) < MIN_GAP;
  endfunction

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    player_key_fsm #(
      .HOLD_DLY      (HOLD_DLY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .sample_ok   (warm_q[1]),
      .key_left_n  (key_left_n[g]),
      .key_right_n (key_right_n[g]),
      .req_left    (req_left[g]),
      .req_right   (req_right[g])
    );
    assign x[g*POS_W +: POS_W] = pos_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      tgt[i] = req_right[i] ? step_right({1'b0, pos_q[i]}) : step_left({1'b0, pos_q[i]});
    end
  end

  // Players are resolved in index order so a lower index claims its target first.
  always_comb begin : p_resolve
    logic [NUM_PLAYERS-1:0] acc_v;
    logic                   clash;
    acc_v  = '0;
    clash  = 1'b0;
    refuse = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (enable && (req_left[i] || req_right[i]) && (tgt[i] != {1'b0, pos_q[i]})) begin
        clash = 1'b0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (j != i && gap_lt(tgt[i], {1'b0, pos_q[j]})) clash = 1'b1;
          if (j < i && acc_v[j] && gap_lt(tgt[i], tgt[j])) clash = 1'b1;
        end
        if (clash) refuse[i] = 1'b1;
        else       acc_v[i]  = 1'b1;
      end
    end
    accept = acc_v;
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pos_d[i] = accept[i] ? tgt[i][POS_W-1:0] : pos_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q     <= '0;
      move_pulse <= '0;
      blocked    <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_q[i]  <= init_pos(i);
        at_min[i] <= (init_pos(i) == POS_W'(X_MIN));
        at_max[i] <= (init_pos(i) == POS_W'(X_MAX));
      end
    end else begin
      warm_q     <= {warm_q[0], 1'b1};
      move_pulse <= accept;
      blocked    <= refuse;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pos_q[i]  <= pos_d[i];
        at_min[i] <= (pos_d[i] == POS_W'(X_MIN));
        at_max[i] <= (pos_d[i] == POS_W'(X_MAX));
      end
    end
  end
endmodule

// File: tb/tb_player_ctrl_multi.sv
// Directed bench for player_ctrl_multi: three configurations, pulse events checked
// against a scoreboard of expected (player, moved/blocked, position) records.

module tb_player_ctrl_multi;
  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] player;
    logic       blk;
    logic [9:0] xv;
  } ev_t;

  ev_t  sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;

  logic [1:0]  kl_a = 2'b11, kr_a = 2'b11, kl_b = 2'b11, kr_b = 2'b11;
  logic        kl_c = 1'b1, kr_c = 1'b1;
  logic [19:0] x_a, x_b;
  logic [9:0]  x_c;
  logic [1:0]  mp_a, bk_a, amin_a, amax_a, mp_b, bk_b, amin_b, amax_b;
  logic        mp_c, bk_c, amin_c, amax_c;

  always #5 clk = ~clk;

  player_ctrl_multi #(.NUM_PLAYERS(2), .X_INIT0(100), .X_SPACING(60),
                      .HOLD_DLY(10), .REPEAT_PERIOD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .key_left_n(kl_a), .key_right_n(kr_a), .x(x_a),
    .move_pulse(mp_a), .blocked(bk_a), .at_min(amin_a), .at_max(amax_a));

  player_ctrl_multi #(.NUM_PLAYERS(2), .X_INIT0(100), .X_SPACING(300),
                      .HOLD_DLY(10), .REPEAT_PERIOD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .key_left_n(kl_b), .key_right_n(kr_b), .x(x_b),
    .move_pulse(mp_b), .blocked(bk_b), .at_min(amin_b), .at_max(amax_b));

  player_ctrl_multi #(.NUM_PLAYERS(1), .X_INIT0(620), .X_SPACING(60),
                      .HOLD_DLY(10), .REPEAT_PERIOD(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .key_left_n(kl_c), .key_right_n(kr_c), .x(x_c),
    .move_pulse(mp_c), .blocked(bk_c), .at_min(amin_c), .at_max(amax_c));

  function automatic logic [31:0] xa(input int p);
    return 32'(x_a[p*10 +: 10]);
  endfunction

  function automatic logic [31:0] xb(input int p);
    return 32'(x_b[p*10 +: 10]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_expect(input int d, input int p, input bit b, input int xv);
    ev_t e;
    e.dut    = 2'(d);
    e.player = 4'(p);
    e.blk    = b;
    e.xv     = 10'(xv);
    sb_q.push_back(e);
  endtask

  task automatic sb_observe(input int d, input int p, input logic b, input logic [9:0] xv);
    ev_t o, e;
    o.dut    = 2'(d);
    o.player = 4'(p);
    o.blk    = b;
    o.xv     = xv;
    n_assert++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_unexpected: observed dut%0d p%0d blk%0d x%0d, expected no event", d, p, b, xv);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_assert++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL sb_event: observed dut%0d p%0d blk%0d x%0d expected dut%0d p%0d blk%0d x%0d",
               o.dut, o.player, o.blk, o.xv, e.dut, e.player, e.blk, e.xv);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (mp_a[p] || bk_a[p]) sb_observe(0, p, bk_a[p], x_a[p*10 +: 10]);
    for (int p = 0; p < 2; p++)
      if (mp_b[p] || bk_b[p]) sb_observe(1, p, bk_b[p], x_b[p*10 +: 10]);
    if (mp_c || bk_c) sb_observe(2, 0, bk_c, x_c);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    tick(2);
    chk("rst_x0", xa(0), 100);
    chk("rst_x1", xa(1), 160);
    chk("rst_at_min_a", 32'(amin_a), 0);
    chk("rst_at_max_a", 32'(amax_a), 0);
    chk("rst_xb1", xb(1), 400);
    chk("rst_c_at_max", 32'(amax_c), 1);
    rst_n = 1'b1;
    tick(20);
    chk("idle_x0", xa(0), 100);
    chk("idle_x1", xa(1), 160);

    // single press: update lands two edges after the first low sample
    kr_a[0] = 1'b0;
    sb_expect(0, 0, 0, 120);
    tick(1); chk("lat_e1", xa(0), 100);
    tick(1); chk("lat_e2", xa(0), 100);
    tick(1); chk("lat_e3", xa(0), 120); chk("lat_pulse", 32'(mp_a[0]), 1);
    tick(1); chk("pulse_width", 32'(mp_a[0]), 0);
    kr_a[0] = 1'b1;
    tick(4);

    // second press would land within MIN_GAP of player 1
    kr_a[0] = 1'b0;
    sb_expect(0, 0, 1, 120);
    tick(3); chk("gap_blocked", 32'(bk_a[0]), 1); chk("gap_x0", xa(0), 120);
    tick(1); chk("gap_blocked_width", 32'(bk_a[0]), 0);
    kr_a[0] = 1'b1;
    tick(4);

    // same-cycle opposing moves: lower index wins
    do_reset();
    kr_a[0] = 1'b0;
    kl_a[1] = 1'b0;
    sb_expect(0, 0, 0, 120);
    sb_expect(0, 1, 1, 160);
    tick(3);
    chk("sim_x0", xa(0), 120);
    chk("sim_x1", xa(1), 160);
    chk("sim_blk1", 32'(bk_a[1]), 1);
    chk("sim_mp1", 32'(mp_a[1]), 0);
    kr_a[0] = 1'b1;
    kl_a[1] = 1'b1;
    tick(4);

    // auto-repeat down to the left bound
    kl_b[0] = 1'b0;
    sb_expect(1, 0, 0, 80);
    sb_expect(1, 0, 0, 60);
    sb_expect(1, 0, 0, 40);
    sb_expect(1, 0, 0, 20);
    sb_expect(1, 0, 0, 0);
    tick(3);  chk("rep_off0", xb(0), 80);
    tick(9);  chk("rep_before10", xb(0), 80);
    tick(1);  chk("rep_off10", xb(0), 60);
    tick(4);  chk("rep_off14", xb(0), 40);
    tick(13); chk("rep_final", xb(0), 0);
    chk("rep_at_min", 32'(amin_b[0]), 1);
    kl_b[0] = 1'b1;
    tick(5);

    // right from X_MAX
    kr_c = 1'b0;
`ifdef PLAYER_WRAP_EN
    sb_expect(2, 0, 0, 0);
    tick(4);
    chk("wrap_x", 32'(x_c), 0);
    chk("wrap_at_min", 32'(amin_c), 1);
    chk("wrap_at_max", 32'(amax_c), 0);
`else
    tick(4);
    chk("sat_x", 32'(x_c), 620);
    chk("sat_at_max", 32'(amax_c), 1);
    chk("sat_at_min", 32'(amin_c), 0);
`endif
    kr_c = 1'b1;
    tick(4);

    // reset during WAIT_HOLD with the key still held afterwards
    do_reset();
    kr_a[0] = 1'b0;
    sb_expect(0, 0, 0, 120);
    tick(5);
    chk("mid_pre", xa(0), 120);
    rst_n = 1'b0;
    #1;
    chk("mid_async_x0", xa(0), 100);
    tick(2);
    rst_n = 1'b1;
    tick(50);
    chk("mid_held_x0", xa(0), 100);
    kr_a[0] = 1'b1;
    tick(4);

    // enable dropped during a hold: no further moves until a new press
    kr_a[0] = 1'b0;
    sb_expect(0, 0, 0, 120);
    tick(4);
    chk("en_first", xa(0), 120);
    enable = 1'b0;
    tick(20);
    chk("en_low_x0", xa(0), 120);
    enable = 1'b1;
    tick(20);
    chk("en_rehold_x0", xa(0), 120);
    kr_a[0] = 1'b1;
    tick(4);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick(1);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
